time_report_tx: RTL and testbench

Serial time reporter for the digital clock. Once per second it snapshots the packed 19-bit current time, formats it as the 10-byte ASCII line "HH:MM:SS\r\n", and shifts it out on a UART TX pin (8N1, LSB first). It sits beside the 7-segment decoder and consumes the same packed time word. The decoder drives the local display; this block reports the same time to an external host.

---
 rtl/time_fmt_pkg.sv | 52 +++++
 rtl/uart_tx_byte.sv | 60 ++++++
 rtl/time_report_tx.sv | 158 +++++++++++++++
 tb/tb_time_report_tx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/time_fmt_pkg.sv
// Shared definitions for the serial time reporter: packed time word layout,
// ASCII constants, line length and the UART bit-period helper.
`timescale 1ns/1ps
package time_fmt_pkg;

  // Packed time word layout
  localparam int TIME_W    = 19;
  localparam int HOUR_LSB  = 14;
  localparam int HOUR_W    = 5;
  localparam int MIN10_LSB = 11;
  localparam int MIN10_W   = 3;
  localparam int MIN_LSB   = 7;
  localparam int MIN_W     = 4;
  localparam int SEC10_LSB = 4;
  localparam int SEC10_W   = 3;
  localparam int SEC_LSB   = 0;
  localparam int SEC_W     = 4;

  // ASCII constants
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // "HH:MM:SS\r\n"
  localparam int LINE_LEN = 10;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_NEXT
  } tx_state_t;

  // Bit period in clock cycles, truncated.
  function automatic int calc_divisor(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Decimal digit to ASCII; anything above 9 is reported as '?'.
  function automatic logic [7:0] bcd_char(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return ASCII_ZERO + {4'd0, digit};
    end
    return ASCII_QMARK;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first. ready is also high in the last cycle of
// the stop bit so a byte offered then starts with no idle gap.
`timescale 1ns/1ps
module uart_tx_byte
  import time_fmt_pkg::*;
#(
  parameter int DIVISOR = 2
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (DIVISOR > 2) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIVISOR - 1);
  localparam logic [3:0]       BIT_LAST  = 4'(FRAME_BITS - 1);

  logic             active;
  logic [3:0]       bit_cnt;
  logic [CNT_W-1:0] baud_cnt;
  logic [8:0]       shreg;

  assign ready = !active || ((bit_cnt == BIT_LAST) && (baud_cnt == BAUD_LAST));

  // Frame sequencer: start bit on accept, then shift data and stop bit out.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      active   <= 1'b0;
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else if (valid && ready) begin
      active   <= 1'b1;
      bit_cnt  <= 4'd0;
      baud_cnt <= '0;
      shreg    <= {1'b1, data};
      tx       <= 1'b0;
    end else if (active) begin
      if (baud_cnt == BAUD_LAST) begin
        baud_cnt <= '0;
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= 4'd0;
          tx      <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx      <= shreg[0];
          shreg   <= {1'b0, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/time_report_tx.sv
// Once-per-second serial time reporter: snapshots the packed time on each
// tick edge and sends "HH:MM:SS\r\n" over an 8N1 UART.
//
// state | meaning
// IDLE  | waiting for an enabled tick edge; snapshot taken on the edge
// LOAD  | first character offered to the UART, busy raised
// SEND  | current byte on the line; next character offered for handoff,
//       | or with index 10 waiting for the final stop bit to finish
// NEXT  | character index advanced after a handoff
`timescale 1ns/1ps
module time_report_tx
  import time_fmt_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic              mclk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              tick,
  input  logic [TIME_W-1:0] present_time,
  output logic              tx,
  output logic              busy,
  output logic              overrun
);

  localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
  localparam logic [3:0] LAST_IDX = 4'(LINE_LEN);

  logic tick_s1, tick_s2, tick_d;
  logic warm, armed;
  logic edge_pulse, trigger;

  tx_state_t         state;
  logic [3:0]        idx;
  logic [TIME_W-1:0] snap;

  logic [7:0] char_data;
  logic [7:0] hour_tens, hour_units;
  logic [4:0] hour, hour_rem;
  logic       byte_valid, byte_ready;

  // Tick synchroniser and edge flop. armed only rises after a real low
  // sample, so a tick already high at reset release is not an edge.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      tick_s1 <= 1'b0;
      tick_s2 <= 1'b0;
      tick_d  <= 1'b0;
      warm    <= 1'b0;
      armed   <= 1'b0;
    end else begin
      tick_s1 <= tick;
      tick_s2 <= tick_s1;
      tick_d  <= tick_s2;
      warm    <= 1'b1;
      if (warm && !tick_s1) begin
        armed <= 1'b1;
      end
    end
  end

  assign edge_pulse = tick_s2 && !tick_d && armed;
  assign trigger    = edge_pulse && en;

  assign hour = snap[HOUR_LSB +: HOUR_W];

  // Character formatter working only from the snapshot.
  always_comb begin
    hour_tens  = ASCII_ZERO;
    hour_rem   = hour;
    if (hour >= 5'd20) begin
      hour_tens = ASCII_ZERO + 8'd2;
      hour_rem  = hour - 5'd20;
    end else if (hour >= 5'd10) begin
      hour_tens = ASCII_ZERO + 8'd1;
      hour_rem  = hour - 5'd10;
    end
    hour_units = ASCII_ZERO + {3'd0, hour_rem};
    if (hour > 5'd23) begin
      hour_tens  = ASCII_QMARK;
      hour_units = ASCII_QMARK;
    end

    char_data = ASCII_LF;
    case (idx)
      4'd0:    char_data = hour_tens;
      4'd1:    char_data = hour_units;
      4'd2:    char_data = ASCII_COLON;
      4'd3:    char_data = bcd_char({1'b0, snap[MIN10_LSB +: MIN10_W]});
      4'd4:    char_data = bcd_char(snap[MIN_LSB +: MIN_W]);
      4'd5:    char_data = ASCII_COLON;
      4'd6:    char_data = bcd_char({1'b0, snap[SEC10_LSB +: SEC10_W]});
      4'd7:    char_data = bcd_char(snap[SEC_LSB +: SEC_W]);
      4'd8:    char_data = ASCII_CR;
      default: char_data = ASCII_LF;
    endcase
  end

  assign byte_valid = (state == ST_LOAD) || ((state == ST_SEND) && (idx != LAST_IDX));

  // Line sequencer: trigger handling, character index, busy and overrun.
  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      idx     <= 4'd0;
      snap    <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (trigger && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            snap  <= present_time;
            idx   <= 4'd0;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (byte_ready) begin
            busy  <= 1'b1;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          idx   <= idx + 4'd1;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (byte_ready) begin
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else begin
              state <= ST_NEXT;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .DIVISOR (DIVISOR)
  ) u_uart (
    .mclk  (mclk),
    .rst_n (rst_n),
    .data  (char_data),
    .valid (byte_valid),
    .ready (byte_ready),
    .tx    (tx)
  );

endmodule

// File: tb/tb_time_report_tx.sv
`timescale 1ns/1ps
module tb_time_report_tx;

  localparam int CLK_HZ = 1000;
  localparam int BAUD   = 100;
  localparam int D      = 10;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tick = 1'b0;
  logic [18:0] present_time = '0;
  logic        tx, busy, overrun;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  int abort_gen = 0;

  time_report_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .mclk         (mclk),
    .rst_n        (rst_n),
    .en           (en),
    .tick         (tick),
    .present_time (present_time),
    .tx           (tx),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 mclk = ~mclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] digit_char(input int d);
    return (d <= 9) ? 8'(48 + d) : 8'h3F;
  endfunction

  // Reference model: the ten characters of the line for a given time word.
  function automatic void push_line(input logic [18:0] t);
    int hour, m10, m, s10, s;
    hour = int'(t[18:14]);
    m10  = int'(t[13:11]);
    m    = int'(t[10:7]);
    s10  = int'(t[6:4]);
    s    = int'(t[3:0]);
    if (hour > 23) begin
      exp_q.push_back(8'h3F);
      exp_q.push_back(8'h3F);
    end else begin
      exp_q.push_back(8'(48 + hour / 10));
      exp_q.push_back(8'(48 + hour % 10));
    end
    exp_q.push_back(8'h3A);
    exp_q.push_back(digit_char(m10));
    exp_q.push_back(digit_char(m));
    exp_q.push_back(8'h3A);
    exp_q.push_back(digit_char(s10));
    exp_q.push_back(digit_char(s));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  // Monitor: UART receiver sampling mid-bit, compares against the scoreboard.
  initial begin
    forever begin
      int         gen;
      logic [7:0] b;
      logic       startb, stopb;
      logic [7:0] e;
      @(negedge mclk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        gen = abort_gen;
        repeat (D / 2) @(negedge mclk);
        startb = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge mclk);
          b[i] = tx;
        end
        repeat (D) @(negedge mclk);
        stopb = tx;
        if (gen == abort_gen) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rx_unexpected: got byte 0x%0h expected no byte", b);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", b, e);
            check("rx_start_stop", {startb, stopb}, 2'b01);
          end
        end
      end
    end
  end

  // mode 0 plain, 1 time changes every 50 cycles, 2 en dropped at 200,
  // 3 second tick edge at 300
  task automatic run_line(input logic [18:0] t, input int mode);
    int lat, cnt, ov_first;
    @(posedge mclk); #1;
    present_time = t;
    push_line(t);
    tick = 1'b1;
    lat = 0;
    do begin
      @(posedge mclk); #1;
      lat++;
    end while (tx !== 1'b0 && lat < 20);
    check("start_latency", lat, 4);
    cnt = 0;
    ov_first = -1;
    while (busy === 1'b1 && cnt < 2000) begin
      cnt++;
      if (mode == 1 && (cnt % 50) == 0) present_time = 19'($urandom);
      if (mode == 2 && cnt == 200) en = 1'b0;
      if (mode == 3) begin
        if (cnt == 280) tick = 1'b0;
        if (cnt == 300) tick = 1'b1;
        if (ov_first < 0 && overrun === 1'b1) ov_first = cnt;
      end
      @(posedge mclk); #1;
    end
    check("busy_cycles", cnt, 1000);
    if (mode == 3) check("overrun_latency", ov_first, 303);
    if (mode == 2) en = 1'b1;
    tick = 1'b0;
    repeat (20) @(posedge mclk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [18:0] t;
    int bad;

    rst_n = 1'b0;
    repeat (3) @(posedge mclk); #1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    en = 1'b1;
    repeat (5) @(posedge mclk);

    // basic line and hour / digit boundaries
    run_line({5'd13, 3'd4, 4'd5, 3'd5, 4'd9}, 0);
    run_line({5'd0, 3'd0, 4'd0, 3'd0, 4'd0}, 0);
    run_line({5'd23, 3'd5, 4'd9, 3'd5, 4'd9}, 0);
    run_line({5'd24, 3'd1, 4'd2, 3'd3, 4'd4}, 0);
    run_line({5'd31, 3'd7, 4'hA, 3'd6, 4'hF}, 0);
    run_line({5'd20, 3'd0, 4'hB, 3'd1, 4'hC}, 0);
    run_line({5'd19, 3'd2, 4'hD, 3'd4, 4'hE}, 0);

    // random times
    for (int i = 0; i < 4; i++) run_line(19'($urandom), 0);

    // snapshot isolation
    run_line(19'($urandom), 1);

    // overrun
    check("overrun_before", overrun, 0);
    run_line({5'd10, 3'd3, 4'd1, 3'd2, 4'd7}, 3);
    check("overrun_sticky", overrun, 1);
    run_line(19'($urandom), 0);
    check("overrun_after_line", overrun, 1);

    // reset mid-line with tick held high through release
    @(posedge mclk); #1;
    t = 19'($urandom);
    present_time = t;
    push_line(t);
    tick = 1'b1;
    repeat (4 + 505) @(posedge mclk);
    #1;
    check("busy_before_reset", busy, 1);
    abort_gen++;
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge mclk); #1;
    check("midline_reset_tx", tx, 1);
    check("midline_reset_busy", busy, 0);
    check("midline_reset_overrun", overrun, 0);
    repeat (5) @(posedge mclk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(posedge mclk); #1;
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("no_line_after_reset", bad, 0);
    tick = 1'b0;
    repeat (10) @(posedge mclk);
    run_line(19'($urandom), 0);

    // enable gating
    @(posedge mclk); #1;
    en = 1'b0;
    tick = 1'b1;
    bad = 0;
    repeat (40) begin
      @(posedge mclk); #1;
      if (busy !== 1'b0 || tx !== 1'b1) bad++;
    end
    check("en_low_no_line", bad, 0);
    check("en_low_overrun", overrun, 0);
    tick = 1'b0;
    repeat (10) @(posedge mclk);
    en = 1'b1;
    run_line(19'($urandom), 2);

    repeat (200) @(posedge mclk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
